// File: rtl/enet_nios_down_timer.sv
// enet_nios_down_timer: loadable down-counting interval timer with prescaler, sticky timeout and maskable irq (PRESCALE_W <= WIDTH)
module enet_nios_down_timer #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write,
  input  logic [WIDTH-1:0] writedata,
  input  logic             read,
  output logic [WIDTH-1:0] readdata,
  output logic             irq,
  output logic             tc_pulse
);
  logic [WIDTH-1:0] count, period, count_n, rd_mux;
  logic [PRESCALE_W-1:0] prescale, pre_cnt;
  logic to, run, ito, cont, run_n, to_n, ito_n;
  logic wr, wr_ctl, wr_per, start, stop, tick, tc;
  assign wr     = chipselect & write;
  assign wr_ctl = wr && address == 3'd1;
  assign wr_per = wr && address == 3'd2;
  assign start  = wr_ctl & writedata[2] & ~writedata[3];
  assign stop   = wr_ctl & writedata[3];
  assign tick   = run && pre_cnt == prescale;
  assign tc     = tick && count == '0;
  always_comb begin
    run_n  = stop ? 1'b0 : start ? 1'b1 : (tc && !cont) ? 1'b0 : run;
    to_n   = tc || (to && !(wr && address == 3'd0));
    ito_n  = wr_ctl ? writedata[0] : ito;
    // a reload coinciding with a PERIOD write takes the incoming value
    count_n = start ? period :
              stop ? count :
              (wr_per && !run) ? writedata :
              !tick ? count :
              count != '0 ? count - 1'b1 :
              cont ? (wr_per ? writedata : period) : count;
    rd_mux = address == 3'd0 ? WIDTH'({run, to}) :
             address == 3'd1 ? WIDTH'({cont, ito}) :
             address == 3'd2 ? period :
             address == 3'd3 ? WIDTH'(prescale) :
             address == 3'd4 ? count : '0;
  end
  always_ff @(posedge clk) begin
    if (sclr) begin
      count    <= '0;
      period   <= '0;
      prescale <= '0;
      pre_cnt  <= '0;
      to       <= 1'b0;
      run      <= 1'b0;
      ito      <= 1'b0;
      cont     <= 1'b0;
      readdata <= '0;
      irq      <= 1'b0;
      tc_pulse <= 1'b0;
    end else begin
      count    <= count_n;
      run      <= run_n;
      to       <= to_n;
      ito      <= ito_n;
      irq      <= to_n & ito_n;
      tc_pulse <= tc;
      pre_cnt  <= (start || stop || !run_n || tick) ? '0 : pre_cnt + 1'b1;
      if (wr_ctl) cont <= writedata[1];
      if (wr_per) period <= writedata;
      if (wr && address == 3'd3) prescale <= writedata[PRESCALE_W-1:0];
      if (chipselect && read) readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_enet_nios_down_timer.sv
// tb_enet_nios_down_timer: table-driven register checks plus directed timing sequences
module tb_enet_nios_down_timer;
  logic clk = 1'b0, sclr = 1'b1, chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [2:0] address = '0;
  logic [15:0] writedata = '0, readdata;
  logic irq, tc_pulse;
  int checks = 0, errors = 0;
  enet_nios_down_timer #(.WIDTH(16), .PRESCALE_W(8)) dut (
    .clk(clk), .sclr(sclr), .chipselect(chipselect), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata), .irq(irq), .tc_pulse(tc_pulse)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        w;
    logic [2:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [20];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask
  task automatic rdchk(input string name, input logic [2:0] a, input logic [15:0] exp);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    chk(name, readdata, exp);
  endtask
  task automatic rst;
    sclr = 1'b1;
    repeat (2) @(negedge clk);
    sclr = 1'b0;
  endtask
  task automatic watch(input int n, input int first, input int step, input int j0, output int cnt, output int bad);
    logic e;
    cnt = 0; bad = 0;
    for (int j = j0 + 1; j <= j0 + n; j++) begin
      @(negedge clk);
      e = (j >= first) && ((j - first) % step == 0);
      if (tc_pulse !== e) bad++;
      if (tc_pulse === 1'b1) cnt++;
    end
  endtask
  initial begin
    int cnt, bad, j;
    vecs = '{
      '{1'b0, 3'd0, 16'h0, 16'h0}, '{1'b0, 3'd1, 16'h0, 16'h0}, '{1'b0, 3'd2, 16'h0, 16'h0},
      '{1'b0, 3'd3, 16'h0, 16'h0}, '{1'b0, 3'd4, 16'h0, 16'h0}, '{1'b0, 3'd5, 16'h0, 16'h0},
      '{1'b0, 3'd6, 16'h0, 16'h0}, '{1'b0, 3'd7, 16'h0, 16'h0},
      '{1'b1, 3'd2, 16'h1234, 16'h0}, '{1'b0, 3'd2, 16'h0, 16'h1234}, '{1'b0, 3'd4, 16'h0, 16'h1234},
      '{1'b1, 3'd3, 16'h01AB, 16'h0}, '{1'b0, 3'd3, 16'h0, 16'h00AB},
      '{1'b1, 3'd1, 16'h0003, 16'h0}, '{1'b0, 3'd1, 16'h0, 16'h0003},
      '{1'b1, 3'd5, 16'h0007, 16'h0}, '{1'b0, 3'd5, 16'h0, 16'h0000}, '{1'b0, 3'd0, 16'h0, 16'h0000},
      '{1'b1, 3'd1, 16'h0000, 16'h0}, '{1'b0, 3'd1, 16'h0, 16'h0000}
    };
    @(negedge clk);
    rst;
    chk("reset_irq", irq, 0);
    chk("reset_tc", tc_pulse, 0);
    chk("reset_rd", readdata, 0);
    foreach (vecs[i]) begin
      if (vecs[i].w) wr(vecs[i].a, vecs[i].d);
      else rdchk($sformatf("vec%0d", i), vecs[i].a, vecs[i].exp);
    end
    // one-shot P=5 N=0
    rst; wr(3'd3, 16'd0); wr(3'd2, 16'd5); wr(3'd1, 16'h5);
    watch(26, 6, 1000, 0, cnt, bad);
    chk("oneshot_cnt", cnt, 1);
    chk("oneshot_bad", bad, 0);
    chk("oneshot_irq", irq, 1);
    rdchk("oneshot_status", 3'd0, 16'h1);
    rdchk("oneshot_count", 3'd4, 16'h0);
    wr(3'd0, 16'h0);
    chk("oneshot_irq_clr", irq, 0);
    // continuous P=2 N=3
    rst; wr(3'd3, 16'd3); wr(3'd2, 16'd2); wr(3'd1, 16'h6);
    watch(40, 12, 12, 0, cnt, bad);
    chk("cont_cnt", cnt, 3);
    chk("cont_bad", bad, 0);
    chk("cont_irq", irq, 0);
    rdchk("cont_status", 3'd0, 16'h3);
    // P=0 continuous: pulse every cycle
    rst; wr(3'd3, 16'd0); wr(3'd2, 16'd0); wr(3'd1, 16'h6);
    watch(10, 1, 1, 0, cnt, bad);
    chk("p0_cnt", cnt, 10);
    chk("p0_bad", bad, 0);
    // P=0xFFFF one-shot
    rst; wr(3'd3, 16'd0); wr(3'd2, 16'hFFFF); wr(3'd1, 16'h4);
    j = 0;
    do begin
      @(negedge clk);
      j++;
    end while (tc_pulse !== 1'b1 && j < 70000);
    chk("ffff_latency", j, 65536);
    // START+STOP, and PERIOD write while running leaves count alone
    rst; wr(3'd3, 16'd3); wr(3'd2, 16'd5); wr(3'd1, 16'h4); wr(3'd2, 16'd9); wr(3'd1, 16'hC);
    rdchk("stop_status", 3'd0, 16'h0);
    rdchk("stop_count", 3'd4, 16'd5);
    rdchk("stop_period", 3'd2, 16'd9);
    // PERIOD=9 written while running: first tc at 6, reload uses 9
    rst; wr(3'd3, 16'd0); wr(3'd2, 16'd5); wr(3'd1, 16'h6); wr(3'd2, 16'd9);
    watch(20, 6, 10, 1, cnt, bad);
    chk("reload_cnt", cnt, 2);
    chk("reload_bad", bad, 0);
    // STATUS write on the terminal-count edge
    rst; wr(3'd3, 16'd0); wr(3'd2, 16'd5); wr(3'd1, 16'h4);
    repeat (5) @(negedge clk);
    wr(3'd0, 16'h0);
    chk("coll_tc", tc_pulse, 1);
    rdchk("coll_status", 3'd0, 16'h1);
    // reset mid-run at count=3 with TO=1
    rst; wr(3'd3, 16'd0); wr(3'd2, 16'd5); wr(3'd1, 16'h7);
    repeat (8) @(negedge clk);
    chk("mid_irq_pre", irq, 1);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    chk("mid_irq", irq, 0);
    chk("mid_tc", tc_pulse, 0);
    chk("mid_rd", readdata, 0);
    watch(30, 1000000, 1, 0, cnt, bad);
    chk("mid_nopulse", cnt, 0);
    for (int a = 0; a < 5; a++) rdchk($sformatf("mid_rd%0d", a), 3'(a), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/enet_nios_down_timer.md
# enet_nios_down_timer

Loadable down-counting interval timer, the count-down counterpart to the up-counting logic-cell counters in the enet_nios system. It sits on the Nios peripheral bus as a register-mapped slave. It gives the Ethernet driver a programmable timeout/tick source: terminal-count pulse, sticky timeout flag, and a maskable interrupt. Count width and prescaler width are parameters.

## Interface
- WIDTH, 16: counter, PERIOD and data-bus width (8..32).
- PRESCALE_W, 8: prescaler register width.
- clk  in  1  single clock; every register updates on its rising edge.
- sclr  in  1  synchronous active-high reset; sampled on clk.
- chipselect  in  1  slave select; qualifies read/write.
- address  in  3  register index.
- write  in  1  write strobe (single-cycle).
- writedata  in  WIDTH  write data.
- read  in  1  read strobe (single-cycle).
- readdata  out  WIDTH  registered read data.
- irq  out  1  interrupt = TO & ITO.
- tc_pulse  out  1  one-cycle terminal-count strobe.

## Operation
Register map (all others read 0, writes ignored):
- 0 STATUS: bit0 TO (sticky timeout), bit1 RUN (read-only). Any write clears TO.
- 1 CONTROL: bit0 ITO (irq enable, stored), bit1 CONT (auto-reload, stored). bit2 START and bit3 STOP are write-1 strobes and read back 0.
- 2 PERIOD: reload value, WIDTH bits.
- 3 PRESCALE: tick divider N; a tick occurs every N+1 clocks.
- 4 COUNT: current counter value, read-only.

Prescaler:
- Counts 0..N. It asserts an internal tick on the cycle it equals N, then wraps to 0.
- It only advances while RUN=1. It is forced to 0 on START, on STOP, and when RUN clears.

Counter:
- Writing PERIOD while RUN=0 loads the counter as well as PERIOD.
- Writing PERIOD while RUN=1 updates the reload value only.
- START loads the counter from PERIOD and sets RUN.
- On a tick with counter≠0, the counter decrements by 1.
- On a tick with counter==0: set TO and pulse tc_pulse.
  - If CONT=1, reload PERIOD and stay running.
  - Otherwise clear RUN; the counter holds at 0.
- The counter never wraps below 0.

Simultaneous events:
- START and STOP in the same write: STOP wins. RUN=0 and the counter is not reloaded.
- TO set and a STATUS write in the same cycle: set wins, and TO stays 1.
- PERIOD write in the same cycle as a reload: the reload takes the new writedata.
- START while running: restarts from PERIOD and clears the prescaler.
- PERIOD=0 with CONT=1: one terminal count on every tick.

sclr:
- Clears everything: counter, PERIOD, PRESCALE, prescaler, TO, RUN, ITO, CONT, readdata, tc_pulse.
- Takes effect on the next edge, mid-count included. It overrides any bus access in the same cycle.

## Timing
- Write effects are visible on the clock edge that samples write & chipselect.
- readdata is valid on the cycle after read & chipselect, so latency is 1. It holds its value until the next read.
- Reads have no side effects.
- Period: with PRESCALE=N and PERIOD=P, START at edge k puts counter=P after k. tc_pulse and TO rise at edge k+(P+1)(N+1) and are visible in the following cycle.
- tc_pulse is high for exactly one clock per terminal count.
- irq is a registered AND of TO and ITO, so it is glitch-free. It falls on the edge where TO is cleared.
- Reset values: readdata=0, irq=0, tc_pulse=0.

## Test plan
- Reset/defaults: assert sclr for 2 cycles, then read addresses 0..7. Expect all reads = 0, irq=0, tc_pulse=0.
- One-shot:
  - Setup: PRESCALE=0, PERIOD=5, CONTROL=0x5 (ITO+START) at edge k.
  - Expect a single tc_pulse after edge k+6.
  - Expect TO=1, irq=1, RUN=0 and COUNT=0 afterwards, with no further pulses in the next 20 cycles.
  - Then write STATUS: expect irq=0 next cycle.
- Continuous with prescaler: PRESCALE=3, PERIOD=2, CONTROL=0x6 (CONT+START). Expect tc_pulse every 12 clocks, and RUN to stay 1.
- Boundary:
  - PERIOD=0 with CONT and PRESCALE=0: expect tc_pulse high every cycle.
  - PERIOD=0xFFFF one-shot: expect terminal count after 65536 cycles.
- Collisions:
  - Write CONTROL=0xC (START+STOP): expect RUN=0.
  - Write STATUS on the exact tc_pulse edge: expect TO=1.
  - Write PERIOD=9 while running: expect the current count unaffected and the next reload to use 9.
- Reset mid-run: assert sclr at counter=3 with TO=1. Expect all state 0 next cycle and no tc_pulse afterwards.
